road_scroll_scheduler: RTL and testbench

Sequences the scrolling road background. It converts player controls (accelerate, brake) and a crash event into a per-frame scroll speed. A phase accumulator then turns that speed into single-cycle update_signal pulses that drive the background scroll counter, one pixel per pulse. It sits between the input/game logic and the background renderer, and also exposes speed and travelled distance to the HUD.

---
 rtl/road_scroll_scheduler.sv | 137 +++++++++++++
 tb/tb_road_scroll_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/road_scroll_scheduler.sv
// Road scroll sequencer: turns accel/brake/crash into a per-frame speed and
// a phase-accumulator-driven stream of one-cycle scroll pulses.
module road_scroll_scheduler #(
    parameter int SPEED_W      = 4,
    parameter int MAX_SPEED    = 15,
    parameter int ACCEL_FRAMES = 8,
    parameter int CRASH_FRAMES = 60,
    parameter int DIST_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              accel,
    input  logic              brake,
    input  logic              crash,
    output logic              update_signal,
    output logic [SPEED_W-1:0] speed,
    output logic [DIST_W-1:0] distance,
    output logic [1:0]        state
);

    localparam int ACC_W = $clog2(ACCEL_FRAMES + 1);
    localparam int TMR_W = $clog2(CRASH_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CRASH = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] phase_q, phase_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [DIST_W-1:0]  dist_q, dist_d;
    logic               pulse_q, pulse_d;
    logic [SPEED_W:0]   sum;

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        tmr_d   = tmr_q;
        dist_d  = dist_q;
        pulse_d = 1'b0;
        // Carry uses the speed before this frame's adjustment.
        sum     = {1'b0, phase_q} + {1'b0, speed_q};
        case (state_q)
            IDLE: begin
                speed_d = '0;
                if (start) begin
                    state_d = RUN;
                    phase_d = '0;
                    acc_d   = '0;
                    tmr_d   = '0;
                end
            end
            RUN: begin
                if (crash) begin
                    state_d = CRASH;
                    speed_d = '0;
                    phase_d = '0;
                    acc_d   = '0;
                    tmr_d   = '0;
                end else if (frame_tick) begin
                    phase_d = sum[SPEED_W-1:0];
                    if (sum[SPEED_W]) begin
                        pulse_d = 1'b1;
                        dist_d  = dist_q + DIST_W'(1);
                    end
                    if (brake) begin
                        speed_d = (speed_q > SPEED_W'(2)) ? speed_q - SPEED_W'(2) : '0;
                        acc_d   = '0;
                    end else if (accel) begin
                        if (acc_q == ACC_W'(ACCEL_FRAMES - 1)) begin
                            acc_d = '0;
                            if (speed_q < SPEED_W'(MAX_SPEED))
                                speed_d = speed_q + SPEED_W'(1);
                        end else begin
                            acc_d = acc_q + ACC_W'(1);
                        end
                    end else begin
                        acc_d = '0;
                    end
                end
            end
            CRASH: begin
                if (frame_tick) begin
                    if (tmr_q == TMR_W'(CRASH_FRAMES - 1)) begin
                        state_d = RUN;
                        speed_d = '0;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                speed_d = '0;
                phase_d = '0;
                acc_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            speed_q <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            tmr_q   <= '0;
            dist_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            tmr_q   <= tmr_d;
            dist_q  <= dist_d;
            pulse_q <= pulse_d;
        end
    end

    assign update_signal = pulse_q;
    assign speed         = speed_q;
    assign distance      = dist_q;
    assign state         = state_q;

endmodule

// File: tb/tb_road_scroll_scheduler.sv
// Directed bench for road_scroll_scheduler: hand-computed speed, pulse and
// distance expectations for each scenario.
module tb_road_scroll_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        accel = 1'b0;
    logic        brake = 1'b0;
    logic        crash = 1'b0;
    logic        update_signal;
    logic [3:0]  speed;
    logic [15:0] distance;
    logic [1:0]  state;

    int checks = 0;
    int passed = 0;

    road_scroll_scheduler dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .accel(accel), .brake(brake), .crash(crash),
        .update_signal(update_signal), .speed(speed), .distance(distance),
        .state(state)
    );

    always #5 clk = ~clk;

    // n isolated frame ticks; counts pulses seen the cycle after each tick and
    // pulses still high one cycle later (which would be too wide).
    task automatic run_ticks(input int n, output int pulses, output int wide);
        pulses = 0;
        wide   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            if (update_signal) pulses++;
            @(negedge clk);
            if (update_signal) wide++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        int p, w;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({state, speed, distance, update_signal} !== 23'd0)
            $display("FAIL reset_init: got st=%b sp=%0d d=%0d u=%b, want all 0", state, speed, distance, update_signal);
        else passed++;
        @(negedge clk) reset = 1'b1;
        pulse_start();
        accel = 1'b1;
        run_ticks(56, p, w);
        checks++; if (speed !== 4'd7 || state !== 2'b01)
            $display("FAIL pre_reset_speed: got sp=%0d st=%b, want 7/01", speed, state);
        else passed++;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if ({state, speed, distance, update_signal} !== 23'd0)
            $display("FAIL async_reset: got st=%b sp=%0d d=%0d u=%b, want all 0", state, speed, distance, update_signal);
        else passed++;
        @(negedge clk) reset = 1'b1;
        run_ticks(2, p, w);
        checks++; if (state !== 2'b00 || speed !== 4'd0 || p !== 0)
            $display("FAIL idle_hold: got st=%b sp=%0d pulses=%0d, want 00/0/0", state, speed, p);
        else passed++;
        accel = 1'b0;
    endtask

    task automatic test_accel();
        int p, w;
        pulse_start();
        checks++; if (state !== 2'b01)
            $display("FAIL start_run: got st=%b, want 01", state);
        else passed++;
        accel = 1'b1;
        run_ticks(7, p, w);
        checks++; if (speed !== 4'd0 || p !== 0)
            $display("FAIL accel_t7: got sp=%0d pulses=%0d, want 0/0", speed, p);
        else passed++;
        run_ticks(1, p, w);
        checks++; if (speed !== 4'd1 || p !== 0)
            $display("FAIL accel_t8: got sp=%0d pulses=%0d, want 1/0", speed, p);
        else passed++;
        run_ticks(8, p, w);
        checks++; if (speed !== 4'd2 || distance !== 16'd0)
            $display("FAIL accel_t16: got sp=%0d d=%0d, want 2/0", speed, distance);
        else passed++;
        run_ticks(8, p, w);
        checks++; if (speed !== 4'd3 || distance !== 16'd1 || w !== 0)
            $display("FAIL accel_t24: got sp=%0d d=%0d wide=%0d, want 3/1/0", speed, distance, w);
        else passed++;
    endtask

    task automatic test_saturate();
        int p, w;
        logic [15:0] d0;
        run_ticks(100, p, w);
        checks++; if (speed !== 4'd15)
            $display("FAIL sat_speed: got %0d, want 15", speed);
        else passed++;
        d0 = distance;
        run_ticks(32, p, w);
        checks++; if (p !== 30 || w !== 0 || speed !== 4'd15)
            $display("FAIL sat_pulses: got pulses=%0d wide=%0d sp=%0d, want 30/0/15", p, w, speed);
        else passed++;
        checks++; if (distance - d0 !== 16'd30)
            $display("FAIL sat_distance: got delta=%0d, want 30", distance - d0);
        else passed++;
    endtask

    task automatic test_brake();
        int p, w;
        accel = 1'b0;
        brake = 1'b1;
        run_ticks(5, p, w);
        checks++; if (speed !== 4'd5)
            $display("FAIL brake_to5: got %0d, want 5", speed);
        else passed++;
        run_ticks(1, p, w);
        checks++; if (speed !== 4'd3) $display("FAIL brake_3: got %0d, want 3", speed); else passed++;
        run_ticks(1, p, w);
        checks++; if (speed !== 4'd1) $display("FAIL brake_1: got %0d, want 1", speed); else passed++;
        run_ticks(1, p, w);
        checks++; if (speed !== 4'd0) $display("FAIL brake_0: got %0d, want 0", speed); else passed++;
        accel = 1'b1;
        run_ticks(1, p, w);
        checks++; if (speed !== 4'd0) $display("FAIL brake_accel: got %0d, want 0", speed); else passed++;
        brake = 1'b0;
        run_ticks(7, p, w);
        checks++; if (speed !== 4'd0) $display("FAIL acc_cleared7: got %0d, want 0", speed); else passed++;
        run_ticks(1, p, w);
        checks++; if (speed !== 4'd1) $display("FAIL acc_cleared8: got %0d, want 1", speed); else passed++;
    endtask

    task automatic test_crash();
        int p, w;
        logic [15:0] d0;
        run_ticks(72, p, w);
        checks++; if (speed !== 4'd10)
            $display("FAIL crash_pre: got %0d, want 10", speed);
        else passed++;
        d0 = distance;
        @(negedge clk) begin crash = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin crash = 1'b0; frame_tick = 1'b0; end
        checks++; if (state !== 2'b10 || speed !== 4'd0 || update_signal !== 1'b0 || distance !== d0)
            $display("FAIL crash_entry: got st=%b sp=%0d u=%b d=%0d, want 10/0/0/%0d", state, speed, update_signal, distance, d0);
        else passed++;
        start = 1'b1;
        run_ticks(59, p, w);
        checks++; if (state !== 2'b10 || p !== 0 || speed !== 4'd0)
            $display("FAIL crash_hold: got st=%b pulses=%0d sp=%0d, want 10/0/0", state, p, speed);
        else passed++;
        run_ticks(1, p, w);
        checks++; if (state !== 2'b01 || speed !== 4'd0 || p !== 0 || distance !== d0)
            $display("FAIL crash_exit: got st=%b sp=%0d pulses=%0d d=%0d, want 01/0/0/%0d", state, speed, p, distance, d0);
        else passed++;
        start = 1'b0;
        accel = 1'b0;
    endtask

    task automatic test_wrap();
        int p, w;
        bit hit;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        pulse_start();
        accel = 1'b1;
        frame_tick = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 80000; i++) begin
            @(negedge clk);
            if (distance === 16'hFFFF) begin hit = 1'b1; break; end
        end
        frame_tick = 1'b0;
        checks++; if (!hit)
            $display("FAIL wrap_reach: got d=%0h, want ffff within cycle budget", distance);
        else passed++;
        pulse_start();
        checks++; if (state !== 2'b01 || speed !== 4'd15 || distance !== 16'hFFFF)
            $display("FAIL start_in_run: got st=%b sp=%0d d=%0h, want 01/15/ffff", state, speed, distance);
        else passed++;
        p = 0;
        for (int i = 0; i < 4 && p == 0; i++) run_ticks(1, p, w);
        checks++; if (p !== 1 || distance !== 16'h0000)
            $display("FAIL wrap: got pulses=%0d d=%0h, want 1/0000", p, distance);
        else passed++;
        accel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accel();
        test_saturate();
        test_brake();
        test_crash();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
